pipelined_cs_addsub: RTL and testbench
======================================

Name: pipelined_cs_addsub

Overview:
Parametrised, pipelined carry-select adder/subtractor for the processor's ALU and address paths. Operands are split into SEG-bit segments. Each pipeline stage resolves one segment by carry-select, using a dual sum selected by the registered carry from the previous stage. Adds valid/ready flow control, sequence tags, flush, and full compare flags (signed/unsigned less-than, equal).

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SEG
SEG, 8, segment width; NSEG = WIDTH/SEG pipeline stages (NSEG >= 1)
TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous; kills all in-flight operations
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid && in_ready
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_sub  input  1  1 = A-B (B inverted, cin=1); 0 = A+B (cin=0)
in_tag  input  TAG_W  user tag
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  A+B or A-B, mod 2^WIDTH
out_cout  output  1  carry out of MSB
out_overflow  output  1  signed overflow
out_lt  output  1  signed A<B (sub only)
out_ltu  output  1  unsigned A<B (sub only)
out_eq  output  1  A==B (sub only)
out_tag  output  TAG_W  tag of the presented result

Behaviour:
- Reset (reset_n low, async): all stage valid bits 0; out_valid 0; out_sum, flags and out_tag 0; in_ready 1 after reset release.
- Stage k (0..NSEG-1) computes segment k from its registered carry-in: sum0/sum1 for cin=0/1, select by carry, register carry-out for stage k+1. Stage 0 carry-in = in_sub.
- Operand segments not yet consumed are skewed through the pipeline with their operation; completed low segments travel forward with it.
- Latency: result presented on out_valid exactly NSEG cycles after acceptance when there is no stall; NSEG=1 gives a single registered stage.
- Flow control: advance = !out_valid || out_ready; in_ready = advance && !flush. When advance=0 the whole pipeline holds; bubbles (valid=0) advance freely. Throughput is 1 op/cycle; no op is dropped or duplicated; order is preserved.
- Outputs stay stable while out_valid && !out_ready.
- Flags, computed in the final stage:
  - overflow = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' is B post-inversion.
  - out_lt = sub && (sum[msb] ^ overflow).
  - out_ltu = sub && !cout.
  - out_eq = sub && (sum == 0).
  - For add, out_lt, out_ltu and out_eq are 0.
- flush: on that edge all valid bits clear, including out_valid; in_ready is 0 in the flush cycle, so no acceptance occurs. flush and reset have no effect on data registers other than the valid bits (reset clears all).
- Reset asserted mid-operation: in-flight ops are lost, outputs go to their reset values immediately.
- Carry propagation across all segments (e.g. 0xFFFFFFFF+1) is exact; the carry is registered per stage, never combinationally chained across stages.

Decomposition:
- Shared package: ALU flag bit positions and the localparam NSEG = WIDTH/SEG with an elaboration-time check that WIDTH % SEG == 0.
- One sub-module, cs_seg_adder (SEG-bit combinational dual-sum carry-select segment with carry-out), instantiated NSEG times inside a generate loop.

Test Plan (WIDTH=32, SEG=8, latency 4):
- Add 0x7FFFFFFF + 0x00000001, out_ready=1 -> 4 cycles later out_sum=0x80000000, overflow=1, cout=0, lt=ltu=eq=0.
- Sub 5-7 -> out_sum=0xFFFFFFFE, cout=0, overflow=0, lt=1, ltu=1, eq=0; sub 0x80000000-1 -> 0x7FFFFFFF, overflow=1, cout=1, lt=1, ltu=0.
- Add 0xFFFFFFFF+1 -> out_sum=0, cout=1 (full-width carry through 4 stages); sub 0x12345678-0x12345678 -> sum 0, eq=1, cout=1.
- Issue 6 back-to-back ops tagged 0..5, out_ready low for 3 cycles once first result is valid -> in_ready=0 during stall, outputs stable, tags emerge 0..5 in order, none lost.
- Accept 3 ops, assert flush one cycle -> out_valid=0 next cycle, no result for those tags ever appears; a new op accepted after flush returns after 4 cycles.
- Assert reset_n=0 mid-stream for 1 cycle -> out_valid drops asynchronously, all outputs 0, in_ready=1 after release, next op completes normally.

Source files
------------

// File: rtl/pipelined_cs_addsub_pkg.sv
// Shared constants for the pipelined carry-select adder/subtractor.
// Flag bit positions and segment-count helper.
package pipelined_cs_addsub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;
  localparam int NSEG      = DEF_WIDTH / DEF_SEG;

  localparam int FLG_OVF = 0;
  localparam int FLG_LT  = 1;
  localparam int FLG_LTU = 2;
  localparam int FLG_EQ  = 3;
  localparam int NFLAG   = 4;

  function automatic int seg_count(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipelined_cs_addsub_cs_seg_adder.sv
// One SEG-bit carry-select segment: both sums are formed up front
// and the incoming carry only drives the final select.
module cs_seg_adder
  import pipelined_cs_addsub_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] s0;
  logic [SEG:0] s1;

  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};

  assign {cout, sum} = cin ? s1 : s0;

endmodule

// File: rtl/pipelined_cs_addsub.sv
// Pipelined carry-select add/sub: one segment per stage, carry
// registered between stages, valid/ready flow control and flush.
module pipelined_cs_addsub
  import pipelined_cs_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             out_lt,
  output logic             out_ltu,
  output logic             out_eq,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSTAGE = seg_count(WIDTH, SEG);

  if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of SEG");
  end

  typedef struct packed {
    logic             sub;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
  } stage_t;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !flush;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    stage_t         d;
    stage_t         n;
    stage_t         q;
    logic           dv;
    logic           qv;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;

    if (k == 0) begin : g_first
      // b is stored already inverted for subtract; cin seeds the +1
      assign dv = in_valid && in_ready;
      assign d  = '{sub:   in_sub,
                    tag:   in_tag,
                    a:     in_a,
                    b:     in_b ^ {WIDTH{in_sub}},
                    sum:   '0,
                    carry: in_sub};
    end else begin : g_next
      assign dv = g_stage[k-1].qv;
      assign d  = g_stage[k-1].q;
    end

    cs_seg_adder #(
      .SEG(SEG)
    ) u_seg (
      .a    (d.a[k*SEG +: SEG]),
      .b    (d.b[k*SEG +: SEG]),
      .cin  (d.carry),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    always_comb begin
      n = d;
      n.sum[k*SEG +: SEG] = seg_sum;
      n.carry = seg_cout;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        qv <= 1'b0;
        q  <= '0;
      end else if (flush) begin
        qv <= 1'b0;
      end else if (adv) begin
        qv <= dv;
        q  <= n;
      end
    end

    if (k == NSTAGE - 1) begin : g_last
      logic             ovf;
      logic [NFLAG-1:0] flags_nxt;
      logic [NFLAG-1:0] flags_q;
      logic             unused_q;

      assign ovf = (d.a[WIDTH-1] == d.b[WIDTH-1]) &&
                   (n.sum[WIDTH-1] != d.a[WIDTH-1]);

      always_comb begin
        flags_nxt          = '0;
        flags_nxt[FLG_OVF] = ovf;
        flags_nxt[FLG_LT]  = d.sub && (n.sum[WIDTH-1] ^ ovf);
        flags_nxt[FLG_LTU] = d.sub && !n.carry;
        flags_nxt[FLG_EQ]  = d.sub && (n.sum == '0);
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          flags_q <= '0;
        end else if (!flush && adv) begin
          flags_q <= flags_nxt;
        end
      end

      assign unused_q     = ^{q.sub, q.a, q.b};
      assign out_valid    = qv;
      assign out_sum      = q.sum;
      assign out_cout     = q.carry;
      assign out_tag      = q.tag;
      assign out_overflow = flags_q[FLG_OVF];
      assign out_lt       = flags_q[FLG_LT];
      assign out_ltu      = flags_q[FLG_LTU];
      assign out_eq       = flags_q[FLG_EQ];
    end
  end

endmodule

// File: tb/tb_pipelined_cs_addsub.sv
// Scoreboard bench for pipelined_cs_addsub (WIDTH=32, SEG=8).
// Reference model uses plain integer arithmetic on whole words.
module tb_pipelined_cs_addsub;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = 4;

  logic          clock;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_sub;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_overflow;
  logic          out_lt;
  logic          out_ltu;
  logic          out_eq;
  logic [TW-1:0] out_tag;

  pipelined_cs_addsub #(
    .WIDTH(W),
    .SEG(8),
    .TAG_W(TW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_sub       (in_sub),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_cout     (out_cout),
    .out_overflow (out_overflow),
    .out_lt       (out_lt),
    .out_ltu      (out_ltu),
    .out_eq       (out_eq),
    .out_tag      (out_tag)
  );

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          lt;
    logic          ltu;
    logic          eq;
    logic [TW-1:0] tag;
    int            acc_cyc;
    int            acc_stalls;
    bit            seen;
  } exp_t;

  exp_t          sb[$];
  logic [TW-1:0] popped_tags[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            stalls   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic sub,
                                 input logic [TW-1:0] tag);
    exp_t         m;
    longint       sa;
    longint       sbv;
    longint       r;
    logic [W:0]   u;
    sa  = $signed(a);
    sbv = $signed(b);
    if (sub) begin
      m.sum  = a - b;
      m.cout = (a >= b);
      r      = sa - sbv;
    end else begin
      u      = {1'b0, a} + {1'b0, b};
      m.sum  = u[W-1:0];
      m.cout = u[W];
      r      = sa + sbv;
    end
    m.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    m.lt   = sub && (sa < sbv);
    m.ltu  = sub && (a < b);
    m.eq   = sub && (a == b);
    m.tag  = tag;
    m.acc_cyc    = 0;
    m.acc_stalls = 0;
    m.seen       = 0;
    return m;
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return {23'd0, e.sum, e.cout, e.ovf, e.lt, e.ltu, e.eq, e.tag};
  endfunction

  function automatic logic [63:0] pack_dut();
    return {23'd0, out_sum, out_cout, out_overflow, out_lt, out_ltu,
            out_eq, out_tag};
  endfunction

  // Monitor and scoreboard: inputs only change just after posedge
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {60'd0, out_tag}, 64'hFFFF);
        end else begin
          chk("result", pack_dut(), pack_exp(sb[0]));
          if (!sb[0].seen) begin
            chk("latency", cyc,
                sb[0].acc_cyc + LAT + (stalls - sb[0].acc_stalls));
            sb[0].seen = 1;
          end
          if (out_ready) begin
            popped_tags.push_back(out_tag);
            void'(sb.pop_front());
          end
        end
      end
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready) begin
        e = model(in_a, in_b, in_sub, in_tag);
        e.acc_cyc    = cyc;
        e.acc_stalls = stalls;
        sb.push_back(e);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [TW-1:0] tag);
    int n;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = tag;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout tag=%0d", tag);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // ef = {cout, overflow, lt, ltu, eq}
  task automatic directed(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sub,
                          input logic [TW-1:0] tag,
                          input logic [W-1:0] es, input logic [4:0] ef);
    issue(a, b, sub, tag);
    repeat (LAT - 1) @(posedge clock);
    #1;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_flags"},
        {out_cout, out_overflow, out_lt, out_ltu, out_eq}, ef);
    chk({nm, "_tag"}, out_tag, tag);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] sp[6];
    sp = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
           32'h1, 32'h00FF00FF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int quiet;
    bit done;
    logic [W-1:0] ra;

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    #12;
    chk("reset_valid", out_valid, 0);
    chk("reset_outs", pack_dut(), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clock);
    #1;

    directed("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 4'd1,
             32'h80000000, 5'b01000);
    directed("sub_5_7", 32'd5, 32'd7, 1'b1, 4'd2,
             32'hFFFFFFFE, 5'b00110);
    directed("sub_min", 32'h80000000, 32'h1, 1'b1, 4'd3,
             32'h7FFFFFFF, 5'b11100);
    directed("add_carry", 32'hFFFFFFFF, 32'h1, 1'b0, 4'd4,
             32'h0, 5'b10000);
    directed("sub_eq", 32'h12345678, 32'h12345678, 1'b1, 4'd5,
             32'h0, 5'b10001);

    // Back-to-back ops with a 3-cycle consumer stall
    popped_tags.delete();
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue($urandom, $urandom, 1'($urandom_range(0, 1)), TW'(i));
      end
      begin
        n = 0;
        do begin
          @(posedge clock);
          #1;
          n++;
        end while (!out_valid && n < 50);
        chk("stall_first_valid", out_valid, 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clock);
          chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("order_count", popped_tags.size(), 6);
    for (int i = 0; i < popped_tags.size(); i++)
      chk("order_tag", popped_tags[i], i);

    // Flush with three ops in flight
    issue(32'd10, 32'd20, 1'b0, 4'd8);
    issue(32'd30, 32'd40, 1'b1, 4'd9);
    issue(32'd50, 32'd60, 1'b0, 4'd10);
    flush = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    quiet = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) quiet++;
    end
    chk("flush_no_result", quiet, 0);
    @(posedge clock);
    #1;
    directed("post_flush", 32'd100, 32'd23, 1'b0, 4'd11,
             32'd123, 5'b00000);

    // Asynchronous reset while a result is held at the output
    out_ready = 1'b0;
    issue(32'h11111111, 32'h22222222, 1'b0, 4'd12);
    issue(32'h33333333, 32'h01010101, 1'b1, 4'd13);
    repeat (4) @(posedge clock);
    #1;
    chk("pre_reset_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_outs", pack_dut(), 0);
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("post_reset_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    directed("post_reset", 32'h0000FFFF, 32'h00000001, 1'b0, 4'd14,
             32'h00010000, 5'b00000);

    // Randomized traffic with random consumer back-pressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          ra = pick();
          if ($urandom_range(0, 7) == 0)
            issue(ra, ra, 1'b1, TW'(i));
          else
            issue(ra, pick(), 1'($urandom_range(0, 1)), TW'(i));
          repeat ($urandom_range(0, 1)) @(posedge clock);
          #0;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("final_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
